venc_hs_enc: RTL
================

// Module: venc_hs_enc
// PURPOSE
// - Transmit-side HS-SCCH/E-AGCH channel encoder; the encoding counterpart of the vdec_hs decode chain.
// - Latches an info word on start, appends UE-ID-masked CRC16 (part2/agch), appends 8 zero tail bits.
// - Convolutionally encodes rate 1/3, K=9, one coded triple per cycle, over a valid/ready stream.
// - Used by the loopback/self-test path and by the reference-model bench feeding vdec_hs.
// PARAMETERS
// - MAX_INFO  32  width of info_data; info_len above MAX_INFO is clipped to MAX_INFO
// - CRC_W     16  CRC length (fixed polynomial, see BEHAVIOUR)
// - TAIL_W     8  tail length = K-1
// PORTS
// - clk           in   1   single clock; the only clock in the block
// - rst_n         in   1   reset, asynchronous, active-low
// - start         in   1   1-cycle pulse; sampled only in IDLE
// - hs_mode       in   2   00 part1 (no CRC), 01 part2, 10/11 agch; latched on start
// - agch_crc_sel  in   1   agch only: 0 mask with ue_id_pri, 1 mask with ue_id_sec; latched on start
// - info_len      in   6   number of info bits, 0..MAX_INFO; latched on start
// - info_data     in   MAX_INFO  info bits; bit info_len-1 is sent first; latched on start
// - ue_id_pri     in   16  primary UE ID, CRC mask
// - ue_id_sec     in   16  secondary UE ID, CRC mask (agch)
// - out_data      out  3   coded triple {g0,g1,g2}
// - out_valid     out  1   out_data valid
// - out_ready     in   1   consumer accepts when out_valid&&out_ready
// - busy          out  1   fsm != IDLE
// - done          out  1   1-cycle pulse in FINISH
// BEHAVIOUR
// - Reset: fsm=IDLE; out_data=0, out_valid=0, done=0, busy=0; shift/CRC/encoder registers 0.
// - FSM: IDLE -start-> INFO -> CRC -> TAIL -> FINISH -> IDLE (1 cycle in FINISH).
//   INFO skipped if info_len==0; CRC skipped if hs_mode==00; TAIL always 8 bits.
// - advance = !out_valid || out_ready. Each advance in INFO/CRC/TAIL consumes one input bit b,
//   registers out_data = {^({b,s}&9'o557), ^({b,s}&9'o663), ^({b,s}&9'o711)} with out_valid=1,
//   then s <= {b, s[7:1]}. Generator MSB weights current bit b; s[7] = previous bit.
// - Encoder state s cleared on start. First out_valid: 2 cycles after the start cycle.
// - Triple count = info_len + (hs_mode!=00 ? 16 : 0) + 8. Last triple accepted -> out_valid=0,
//   fsm=FINISH next cycle, done=1 for that cycle, busy drops the cycle after.
// - CRC16: poly x^16+x^12+x^5+1, init 0, no reflection, fed with info bits MSB-first during INFO.
//   CRC phase sends crc[15] first, each bit XORed with mask[15..0] (mask = ue_id_pri, or
//   ue_id_sec when agch and agch_crc_sel=1).
// - Backpressure: out_valid && !out_ready holds out_data, fsm, counters, s, CRC unchanged; no loss.
// - start while busy: ignored, no effect on latched inputs. ue_id_* sampled at start (latched).
// - Reset mid-operation: immediate return to reset values; partial frame discarded.
// - Bit counter 6 bits, compared against phase length; no wrap within a frame.
// STRUCTURE
// - Shared package vdec_hs_pkg: hs_mode encodings (PART1/PART2/AGCH), FSM state codes,
//   generator constants 9'o557/9'o663/9'o711, CRC16 poly 16'h1021, TAIL_W.
// - One sub-module: venc_conv_k9 (8-bit state, enable, clear, 1 bit in -> 3 bits out, comb parity).
// - CRC16 serial update inline in top level.
// TESTING
// - mode 00, info_len=8, info=0 -> 16 triples all 3'b000, done 1 cycle after last accept.
// - mode 00, info_len=1, info[0]=1 -> triples 111,011,101,110,010,101,100,110,111 (impulse response).
// - mode 01, info_len=13 all zero, ue_id_pri=16'hA5A5 -> 37 triples = encode of 13 zeros,
//   bits A5A5 MSB-first, 8 zeros; mode 10 agch_crc_sel=1 uses ue_id_sec instead.
// - Backpressure: out_ready low 5 cycles at triple 4 -> out_data stable, full sequence unchanged.
// - start pulsed while busy with different info -> ignored; output equals first frame.
// - rst_n low at triple 10 -> all outputs 0 asynchronously; next start produces clean frame.

Source files
------------

// File: rtl/vdec_hs_pkg.sv
// vdec_hs_pkg: shared HS-SCCH/E-AGCH constants (mode codes, FSM states, code generators, CRC poly)
package vdec_hs_pkg;
  typedef enum logic [1:0] {PART1 = 2'b00, PART2 = 2'b01, AGCH = 2'b10} hs_mode_e;
  typedef enum logic [2:0] {IDLE, INFO, CRC, TAIL, FINISH} state_t;
  localparam int CRC_W = 16;
  localparam int TAIL_W = 8;
  localparam logic [8:0] G0 = 9'o557;
  localparam logic [8:0] G1 = 9'o663;
  localparam logic [8:0] G2 = 9'o711;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
endpackage

// File: rtl/venc_conv_k9.sv
// venc_conv_k9: rate-1/3 K=9 convolutional encoder; bit 8 of each generator weights the current bit
module venc_conv_k9
  import vdec_hs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       b,
  output logic [2:0] g
);
  logic [7:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else if (clr) s <= '0;
    else if (en) s <= {b, s[7:1]};
  always_comb g = {^({b, s} & G0), ^({b, s} & G1), ^({b, s} & G2)};
endmodule

// File: rtl/venc_hs_enc.sv
// venc_hs_enc: HS-SCCH/E-AGCH encoder; info + UE-ID-masked CRC16 + zero tail, K=9 rate-1/3 coded
module venc_hs_enc
  import vdec_hs_pkg::*;
#(
  parameter int MAX_INFO = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          hs_mode,
  input  logic                agch_crc_sel,
  input  logic [5:0]          info_len,
  input  logic [MAX_INFO-1:0] info_data,
  input  logic [15:0]         ue_id_pri,
  input  logic [15:0]         ue_id_sec,
  output logic [2:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);
  state_t              state, nxt;
  logic                part1, adv, gen, last, b, enc_clr;
  logic [5:0]          len, cnt, plen, clip_len;
  logic [MAX_INFO-1:0] info_sh;
  logic [CRC_W-1:0]    crc, mask;
  logic [2:0]          g;

  always_comb begin
    clip_len = info_len > 6'(MAX_INFO) ? 6'(MAX_INFO) : info_len;
    adv = !out_valid || out_ready;
    gen = state == INFO || state == CRC || (state == TAIL && cnt != 6'(TAIL_W));
    plen = state == INFO ? len : state == CRC ? 6'(CRC_W) : 6'(TAIL_W);
    last = cnt == plen - 6'd1;
    b = state == INFO ? info_sh[MAX_INFO-1] : state == CRC ? crc[CRC_W-1] ^ mask[CRC_W-1] : 1'b0;
    nxt = state == INFO ? (part1 ? TAIL : CRC) : TAIL;
    enc_clr = state == IDLE && start;
    busy = state != IDLE;
  end

  venc_conv_k9 u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv && gen),
    .clr   (enc_clr),
    .b     (b),
    .g     (g)
  );

  // TAIL parks at cnt==TAIL_W until its last triple is accepted, then FINISH
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      part1 <= 1'b0;
      len <= '0;
      cnt <= '0;
      info_sh <= '0;
      crc <= '0;
      mask <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          part1 <= hs_mode == PART1;
          len <= clip_len;
          cnt <= '0;
          info_sh <= info_data << (MAX_INFO - int'(clip_len));
          crc <= '0;
          mask <= (hs_mode >= AGCH && agch_crc_sel) ? ue_id_sec : ue_id_pri;
          state <= clip_len == '0 ? (hs_mode == PART1 ? TAIL : CRC) : INFO;
        end
        FINISH: state <= IDLE;
        default: if (adv) begin
          if (gen) begin
            out_data <= g;
            out_valid <= 1'b1;
            cnt <= (last && state != TAIL) ? '0 : cnt + 6'd1;
            if (last) state <= nxt;
            if (state == INFO) begin
              info_sh <= info_sh << 1;
              crc <= {crc[CRC_W-2:0], 1'b0} ^ ((b ^ crc[CRC_W-1]) ? CRC_POLY : '0);
            end
            if (state == CRC) begin
              crc <= crc << 1;
              mask <= mask << 1;
            end
          end else begin
            out_valid <= 1'b0;
            done <= 1'b1;
            state <= FINISH;
          end
        end
      endcase
    end
endmodule
